// File: rtl/scope_pkg.sv
// rtl/scope_pkg.sv - shared types and defaults for the scope acquisition engine
package scope_pkg;

  localparam int DW_DEF  = 10;
  localparam int AW_DEF  = 10;
  localparam int DCW_DEF = 16;

  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    WAIT,
    POST,
    DONE
  } cap_state_t;

endpackage

// File: rtl/scope_sample_ram.sv
// rtl/scope_sample_ram.sv - simple dual-port sample buffer, registered read, no reset
module scope_sample_ram #(
  parameter int DW = 10,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // capture-side write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // host-side read port, one cycle of latency
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/scope_capture.sv
// rtl/scope_capture.sv - decimating, triggered circular-buffer ADC capture engine
module scope_capture
  import scope_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int AW  = AW_DEF,
  parameter int DCW = DCW_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  output logic           adc_clk,
  input  logic [DW-1:0]  adc_data,
  input  logic           arm,
  input  logic           force_trig,
  input  logic [DW-1:0]  trig_level,
  input  logic           trig_edge,
  input  logic [DCW-1:0] decim,
  input  logic [AW-1:0]  pre_len,
  output logic           busy,
  output logic           triggered,
  output logic           done,
  output logic [AW-1:0]  trig_ptr,
  input  logic           rd_en,
  input  logic [AW-1:0]  rd_addr,
  output logic [DW-1:0]  rd_data,
  output logic           rd_valid
);

  cap_state_t           state, state_d;
  logic signed [DW-1:0] s_cur, s_prev;
  logic [DCW-1:0]       dcnt;
  logic                 strobe;
  logic [AW-1:0]        wr_ptr, fill_cnt, post_cnt, pre_len_q, post_init;
  logic                 force_pend;
  logic                 level_hit, trig_fire, wr_en;
  logic [AW-1:0]        rd_phys;
  logic [DW-1:0]        ram_q;

  assign adc_clk   = clk;
  assign strobe    = (dcnt == '0);
  assign busy      = (state == FILL) || (state == WAIT) || (state == POST);
  assign done      = (state == DONE);
  // DEPTH-1 is all ones, so the post-trigger window is the complement of the history
  assign post_init = {AW{1'b1}} - pre_len_q;
  // logical index 0 is the oldest retained sample, pre_len_q is the trigger sample
  assign rd_phys   = trig_ptr - pre_len_q + rd_addr;
  assign rd_data   = rd_valid ? ram_q : '0;

  // input register; s_prev only advances on kept (decimated) samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_cur  <= '0;
      s_prev <= '0;
    end else begin
      s_cur <= $signed(adc_data);
      if (strobe) s_prev <= s_cur;
    end
  end

  // decimation down-counter, strobe when it hits zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               dcnt <= '0;
    else if (arm || strobe)   dcnt <= decim;
    else                      dcnt <= dcnt - 1'b1;
  end

  // signed level crossing between consecutive kept samples
  always_comb begin
    level_hit = 1'b0;
    if (trig_edge == EDGE_RISE)
      level_hit = (s_prev < $signed(trig_level)) && (s_cur >= $signed(trig_level));
    else
      level_hit = (s_prev > $signed(trig_level)) && (s_cur <= $signed(trig_level));
  end

  // capture state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // next-state and write/trigger decisions; arm overrides everything
  always_comb begin
    state_d   = state;
    wr_en     = 1'b0;
    trig_fire = 1'b0;
    case (state)
      IDLE: ;
      FILL: begin
        if (fill_cnt == pre_len_q) begin
          state_d = WAIT;
        end else if (strobe) begin
          wr_en = 1'b1;
          if (fill_cnt + 1'b1 == pre_len_q) state_d = WAIT;
        end
      end
      WAIT: begin
        if (strobe) begin
          wr_en = 1'b1;
          if (level_hit || force_pend || force_trig) begin
            trig_fire = 1'b1;
            state_d   = (post_init == '0) ? DONE : POST;
          end
        end
      end
      POST: begin
        if (strobe) begin
          wr_en = 1'b1;
          // post_cnt counts writes still owed, so the last one is at 1
          if (post_cnt == AW'(1)) state_d = DONE;
        end
      end
      DONE: ;
      default: state_d = IDLE;
    endcase
    if (arm) begin
      state_d   = FILL;
      wr_en     = 1'b0;
      trig_fire = 1'b0;
    end
  end

  // pointers, counters and trigger bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      fill_cnt   <= '0;
      post_cnt   <= '0;
      pre_len_q  <= '0;
      trig_ptr   <= '0;
      triggered  <= 1'b0;
      force_pend <= 1'b0;
    end else if (arm) begin
      pre_len_q  <= pre_len;
      wr_ptr     <= '0;
      fill_cnt   <= '0;
      post_cnt   <= '0;
      triggered  <= 1'b0;
      force_pend <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (wr_en && state == FILL) fill_cnt <= fill_cnt + 1'b1;
      if (wr_en && state == POST) post_cnt <= post_cnt - 1'b1;
      if (trig_fire) begin
        trig_ptr   <= wr_ptr;
        triggered  <= 1'b1;
        post_cnt   <= post_init;
        force_pend <= 1'b0;
      end else if (state == WAIT && force_trig) begin
        force_pend <= 1'b1;
      end
    end
  end

  // reads are honoured only once the buffer is frozen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_valid <= 1'b0;
    else        rd_valid <= rd_en && (state == DONE);
  end

  scope_sample_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (s_cur),
    .re    (rd_en),
    .raddr (rd_phys),
    .rdata (ram_q)
  );

endmodule
